// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode enum and the occupancy-counter width helper.
// Also used by the dual-clock FIFO bench.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // One extra bit so occupancy can represent DEPTH itself.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array with one synchronous write port and one asynchronous read port.
// There is no reset on the array; its contents are only meaningful behind valid pointers.
module fifo_mem #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with fill count, programmable almost-full/almost-empty flags,
// a selectable standard/FWFT read mode and sticky overflow/underflow flags.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int         CW   = count_width(ADDR_WIDTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (DEPTH != 2**ADDR_WIDTH) begin : g_bad_depth
        $fatal(1, "sync_fifo_prog: DEPTH must equal 2**ADDR_WIDTH");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $fatal(1, "sync_fifo_prog: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_acc, rd_acc;

    // Flags come straight from the registered count, so they move one edge after the access.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // No pass-through: a write at full or a read at empty is refused regardless of the other port.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    fifo_mem #(
        .AW (ADDR_WIDTH),
        .DW (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        wr_ptr_d  = wr_acc ? wr_ptr_q + CW'(1) : wr_ptr_q;
        rd_ptr_d  = rd_acc ? rd_ptr_q + CW'(1) : rd_ptr_q;
        count_d   = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        rd_data_d = rd_data_q;
        if (MODE == FIFO_STD && rd_acc) begin
            rd_data_d = mem_rdata;
        end
        // A new error wins over a simultaneous clear.
        ovf_d = (wr_en && full)  ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
        unf_d = (rd_en && empty) ? 1'b1 : (err_clr ? 1'b0 : unf_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rd_data_q <= rd_data_d;
        end
    end

    // FWFT shows the head word directly; it reads as zero while there is no valid head.
    if (MODE == FIFO_FWFT) begin : g_fwft
        assign rd_data = empty ? '0 : mem_rdata;
    end else begin : g_std
        assign rd_data = rd_data_q;
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a standard-mode and an FWFT instance share stimulus and are
// compared every cycle against a queue-based reference of the FIFO contract.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en, err_clr;
    logic [7:0] wr_data;

    logic       s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
    logic [7:0] s_rd_data;
    logic [3:0] s_count;
    logic       f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
    logic [7:0] f_rd_data;
    logic [3:0] f_count;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [7:0] q[$];
    logic       m_ovf, m_unf;
    logic [7:0] m_std_rd;

    always #5 clk = ~clk;

    sync_fifo_prog #(.FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(s_full), .almost_full(s_afull), .rd_en(rd_en), .rd_data(s_rd_data),
        .empty(s_empty), .almost_empty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr)
    );

    sync_fifo_prog #(.FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_full), .almost_full(f_afull), .rd_en(rd_en), .rd_data(f_rd_data),
        .empty(f_empty), .almost_empty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_std_rd = 8'h00;
    endtask

    task automatic check_all(input string ph);
        int         n;
        logic [7:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : 8'h00;
        check_val({ph, " std count"},  32'(s_count),  32'(n));
        check_val({ph, " std full"},   32'(s_full),   32'(n == 8));
        check_val({ph, " std empty"},  32'(s_empty),  32'(n == 0));
        check_val({ph, " std afull"},  32'(s_afull),  32'(n >= 6));
        check_val({ph, " std aempty"}, 32'(s_aempty), 32'(n <= 2));
        check_val({ph, " std ovf"},    32'(s_ovf),    32'(m_ovf));
        check_val({ph, " std unf"},    32'(s_unf),    32'(m_unf));
        check_val({ph, " std rd_data"},32'(s_rd_data),32'(m_std_rd));
        check_val({ph, " fwft count"}, 32'(f_count),  32'(n));
        check_val({ph, " fwft empty"}, 32'(f_empty),  32'(n == 0));
        check_val({ph, " fwft full"},  32'(f_full),   32'(n == 8));
        check_val({ph, " fwft ovf"},   32'(f_ovf),    32'(m_ovf));
        check_val({ph, " fwft unf"},   32'(f_unf),    32'(m_unf));
        check_val({ph, " fwft rd_data"},32'(f_rd_data),32'(head));
    endtask

    // One clock of stimulus; the reference applies the FIFO rules using the occupancy seen before the edge.
    task automatic step(input string ph, input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        bit was_full, was_empty;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        err_clr = clr;
        @(posedge clk);
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        if (rd && !was_empty) m_std_rd = q.pop_front();
        if (wr && !was_full)  q.push_back(d);
        m_ovf = (wr && was_full)  ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = (rd && was_empty) ? 1'b1 : (clr ? 1'b0 : m_unf);
        #1;
        check_all(ph);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // fill 0x11..0x88, then one write too many
        for (int i = 1; i <= 8; i++) step("fill", 1, 8'(i * 8'h11), 0, 0);
        step("overflow", 1, 8'hEE, 0, 0);

        // drain in order, then one read too many
        for (int i = 0; i < 8; i++) step("drain", 0, 8'h00, 1, 0);
        step("underflow", 0, 8'h00, 1, 0);
        step("err_clr", 0, 8'h00, 0, 1);

        // wrap across the index 7 -> 0 boundary
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) step("wrap wr", 1, 8'($urandom), 0, 0);
            for (int i = 0; i < 5; i++) step("wrap rd", 0, 8'h00, 1, 0);
        end
        for (int i = 0; i < 3; i++) step("wrap wr3", 1, 8'($urandom), 0, 0);

        // simultaneous traffic at count 4, at full and at empty
        step("to4", 1, 8'h44, 0, 0);
        for (int i = 0; i < 10; i++) step("wr+rd@4", 1, 8'($urandom), 1, 0);
        for (int i = 0; i < 4; i++) step("to8", 1, 8'($urandom), 0, 0);
        step("wr+rd@full", 1, 8'hBB, 1, 0);
        for (int i = 0; i < 7; i++) step("to0", 0, 8'h00, 1, 0);
        step("wr+rd@empty", 1, 8'hA5, 1, 0);
        step("pop", 0, 8'h00, 1, 0);

        // FWFT head visible without rd_en, pop exposes the next head
        step("fwft wr", 1, 8'hA5, 0, 0);
        step("fwft wr2", 1, 8'h5A, 0, 0);
        step("fwft idle", 0, 8'h00, 0, 0);
        step("fwft pop", 0, 8'h00, 1, 0);
        step("fwft pop2", 0, 8'h00, 1, 0);

        // clear racing a new error keeps the flag set
        step("unf again", 0, 8'h00, 1, 0);
        step("clr+err", 0, 8'h00, 1, 1);
        step("clr", 0, 8'h00, 0, 1);

        // mid-burst async reset at count 5 with overflow set
        for (int i = 0; i < 8; i++) step("burst", 1, 8'($urandom), 0, 0);
        step("burst ovf", 1, 8'h99, 0, 0);
        for (int i = 0; i < 3; i++) step("burst rd", 0, 8'h00, 1, 0);
        wr_en = 1'b1; rd_en = 1'b0; wr_data = 8'h77;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async rst");
        @(negedge clk);
        rst = 1'b0;
        step("post rst", 1, 8'h31, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit wr, rd, clr;
            wr  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
            rd  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
            clr = ($urandom_range(0, 19) == 0);
            step("rand", wr, 8'($urandom), rd, clr);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
